rp_seek_ctrl: RTL and testbench

- Per-drive positioner sequencer for the RPxx disk emulation.
- Takes SEEK, RECAL and PRESET commands and the desired cylinder address held in the RPDC register.
- Steps a current-cylinder register (CCA) toward the target at a programmable rate, then settles and raises attention.
- Owns drive-ready and positioning-in-progress status, and tracks mid-transfer cylinder increments so CCA stays equal to DCA after spiral transfers.

---
 rtl/rp_seek_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_rp_seek_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_seek_ctrl.sv
// ---------------------------------------------------------------------------
// rp_seek_ctrl
// Per-drive positioner sequencer for the RPxx disk emulation. It accepts
// SEEK / RECAL / PRESET command strobes and steps the current cylinder
// address toward the requested cylinder at a fixed rate. It then waits for
// the heads to settle and raises attention. It also follows cylinder
// increments from the transfer logic so that CCA tracks DCA across spiral
// transfers.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   rpSEEK    in   one-clock seek strobe
//   rpRECAL   in   one-clock recalibrate strobe
//   rpPRESET  in   one-clock preset strobe
//   rpINCCYL  in   one-clock cylinder increment from the transfer logic
//   rpDCA     in   [9:0] desired cylinder address (RPDC)
//   rpATACLR  in   one-clock attention clear
//   rpCCA     out  [9:0] current cylinder address
//   rpDRY     out  drive ready
//   rpPIP     out  positioning in progress
//   rpATA     out  attention
//   rpIVC     out  invalid cylinder error
//   rpSKDONE  out  one-clock pulse on seek/recal completion
// ---------------------------------------------------------------------------
module rp_seek_ctrl #(
   parameter int NUM_CYL    = 815,
   parameter int STEP_DLY   = 100,
   parameter int SETTLE_DLY = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rpSEEK,
   input  logic       rpRECAL,
   input  logic       rpPRESET,
   input  logic       rpINCCYL,
   input  logic [9:0] rpDCA,
   input  logic       rpATACLR,
   output logic [9:0] rpCCA,
   output logic       rpDRY,
   output logic       rpPIP,
   output logic       rpATA,
   output logic       rpIVC,
   output logic       rpSKDONE
);

   localparam int STEP_W   = (STEP_DLY   > 1) ? $clog2(STEP_DLY)   : 1;
   localparam int SETTLE_W = (SETTLE_DLY > 1) ? $clog2(SETTLE_DLY) : 1;
   localparam logic [STEP_W-1:0]   STEP_LOAD   = STEP_W'(STEP_DLY - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_DLY - 1);
   localparam logic [9:0]          CYL_MAX     = 10'(NUM_CYL - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      STEP,
      SETTLE,
      DONE
   } state_t;

   state_t              r_state,     w_stateNxt;
   logic [9:0]          r_target,    w_targetNxt;
   logic [STEP_W-1:0]   r_stepTmr,   w_stepTmrNxt;
   logic [SETTLE_W-1:0] r_settleTmr, w_settleTmrNxt;
   logic [9:0]          r_cca,       w_ccaNxt;
   logic                r_dry,       w_dryNxt;
   logic                r_pip,       w_pipNxt;
   logic                r_ata,       w_ataNxt;
   logic                r_ivc,       w_ivcNxt;
   logic                r_skDone,    w_skDoneNxt;
   logic                w_ataSet;
   logic                w_ataPresetClr;
   logic [9:0]          w_stepCca;

   // Cylinder after one step toward the target; only used while stepping,
   // when the target is known to differ from the current cylinder.
   assign w_stepCca = (r_target > r_cca) ? (r_cca + 10'd1) : (r_cca - 10'd1);

   // State and status registers. Reset overrides everything, including a
   // seek in flight, so an aborted seek never produces a completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_target    <= '0;
         r_stepTmr   <= '0;
         r_settleTmr <= '0;
         r_cca       <= '0;
         r_dry       <= 1'b1;
         r_pip       <= 1'b0;
         r_ata       <= 1'b0;
         r_ivc       <= 1'b0;
         r_skDone    <= 1'b0;
      end else begin
         r_state     <= w_stateNxt;
         r_target    <= w_targetNxt;
         r_stepTmr   <= w_stepTmrNxt;
         r_settleTmr <= w_settleTmrNxt;
         r_cca       <= w_ccaNxt;
         r_dry       <= w_dryNxt;
         r_pip       <= w_pipNxt;
         r_ata       <= w_ataNxt;
         r_ivc       <= w_ivcNxt;
         r_skDone    <= w_skDoneNxt;
      end
   end

   // Next-state and next-status logic. Commands are only decoded in IDLE,
   // apart from PRESET, which may clear the error flag while the heads move.
   // Attention is collected as set/clear requests and resolved at the end so
   // that a same-clock set always wins over a clear.
   always_comb begin
      w_stateNxt     = r_state;
      w_targetNxt    = r_target;
      w_stepTmrNxt   = r_stepTmr;
      w_settleTmrNxt = r_settleTmr;
      w_ccaNxt       = r_cca;
      w_dryNxt       = r_dry;
      w_pipNxt       = r_pip;
      w_ivcNxt       = r_ivc;
      w_skDoneNxt    = 1'b0;
      w_ataSet       = 1'b0;
      w_ataPresetClr = 1'b0;

      case (r_state)
         IDLE: begin
            if (rpPRESET) begin
               w_ivcNxt       = 1'b0;
               w_ataPresetClr = 1'b1;
            end else if (rpRECAL) begin
               w_targetNxt = '0;
               w_dryNxt    = 1'b0;
               w_pipNxt    = 1'b1;
               w_stateNxt  = CHECK;
            end else if (rpSEEK) begin
               if (int'(rpDCA) >= NUM_CYL) begin
                  w_ivcNxt = 1'b1;
                  w_ataSet = 1'b1;
                  w_pipNxt = 1'b0;
                  w_dryNxt = 1'b1;
               end else begin
                  w_targetNxt = rpDCA;
                  w_dryNxt    = 1'b0;
                  w_pipNxt    = 1'b1;
                  w_stateNxt  = CHECK;
               end
            end else if (rpINCCYL) begin
               if (r_cca == CYL_MAX) begin
                  w_ivcNxt = 1'b1;
                  w_ataSet = 1'b1;
               end else begin
                  w_ccaNxt = r_cca + 10'd1;
               end
            end
         end

         CHECK: begin
            if (r_target == r_cca) begin
               w_settleTmrNxt = SETTLE_LOAD;
               w_stateNxt     = SETTLE;
            end else begin
               w_stepTmrNxt = STEP_LOAD;
               w_stateNxt   = STEP;
            end
         end

         STEP: begin
            if (r_stepTmr == '0) begin
               w_ccaNxt = w_stepCca;
               if (w_stepCca == r_target) begin
                  w_settleTmrNxt = SETTLE_LOAD;
                  w_stateNxt     = SETTLE;
               end else begin
                  w_stepTmrNxt = STEP_LOAD;
               end
            end else begin
               w_stepTmrNxt = r_stepTmr - STEP_W'(1);
            end
         end

         SETTLE: begin
            if (r_settleTmr == '0) begin
               w_stateNxt = DONE;
            end else begin
               w_settleTmrNxt = r_settleTmr - SETTLE_W'(1);
            end
         end

         DONE: begin
            w_skDoneNxt = 1'b1;
            w_ataSet    = 1'b1;
            w_pipNxt    = 1'b0;
            w_dryNxt    = 1'b1;
            w_stateNxt  = IDLE;
         end

         default: begin
            w_stateNxt = IDLE;
         end
      endcase

      if ((r_state != IDLE) && rpPRESET) begin
         w_ivcNxt = 1'b0;
      end

      if (w_ataSet) begin
         w_ataNxt = 1'b1;
      end else if (rpATACLR || w_ataPresetClr) begin
         w_ataNxt = 1'b0;
      end else begin
         w_ataNxt = r_ata;
      end
   end

   assign rpCCA    = r_cca;
   assign rpDRY    = r_dry;
   assign rpPIP    = r_pip;
   assign rpATA    = r_ata;
   assign rpIVC    = r_ivc;
   assign rpSKDONE = r_skDone;

endmodule

// File: tb/tb_rp_seek_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rp_seek_ctrl
// Self-checking bench for rp_seek_ctrl with short step/settle delays. The
// reference model keeps only the drive's architectural state (cylinder,
// IVC, ATA). Seek timing is predicted from the closed-form seek-time rule:
// after strobe edge k the cylinder has moved min(d, (k-1)/STEP) steps, and
// the drive is ready again at k = d*STEP + SETTLE + 2.
// ---------------------------------------------------------------------------
module tb_rp_seek_ctrl;

   localparam int S  = 4;
   localparam int ST = 3;
   localparam int NC = 815;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rpSEEK = 1'b0;
   logic       rpRECAL = 1'b0;
   logic       rpPRESET = 1'b0;
   logic       rpINCCYL = 1'b0;
   logic [9:0] rpDCA = '0;
   logic       rpATACLR = 1'b0;
   logic [9:0] rpCCA;
   logic       rpDRY;
   logic       rpPIP;
   logic       rpATA;
   logic       rpIVC;
   logic       rpSKDONE;

   int nCompared   = 0;
   int nMismatched = 0;

   int mCca = 0;
   bit mIvc = 1'b0;
   bit mAta = 1'b0;

   rp_seek_ctrl #(
      .NUM_CYL   (NC),
      .STEP_DLY  (S),
      .SETTLE_DLY(ST)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rpSEEK  (rpSEEK),
      .rpRECAL (rpRECAL),
      .rpPRESET(rpPRESET),
      .rpINCCYL(rpINCCYL),
      .rpDCA   (rpDCA),
      .rpATACLR(rpATACLR),
      .rpCCA   (rpCCA),
      .rpDRY   (rpDRY),
      .rpPIP   (rpPIP),
      .rpATA   (rpATA),
      .rpIVC   (rpIVC),
      .rpSKDONE(rpSKDONE)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance past one rising edge and settle 1 time unit after it, then
   // drop every strobe so each one lasts exactly one clock.
   task automatic tick();
      @(posedge clk);
      #1;
      rpSEEK   = 1'b0;
      rpRECAL  = 1'b0;
      rpPRESET = 1'b0;
      rpINCCYL = 1'b0;
      rpATACLR = 1'b0;
   endtask

   // Compare every output against the model's idle picture.
   task automatic checkIdle(input string tag);
      if (rpCCA !== 10'(mCca)) begin
         nMismatched++;
         $display("[TB] FAIL %s cca: got %0d want %0d", tag, rpCCA, mCca);
      end
      nCompared++;
      if (rpIVC !== mIvc) begin
         nMismatched++;
         $display("[TB] FAIL %s ivc: got %0b want %0b", tag, rpIVC, mIvc);
      end
      nCompared++;
      if (rpATA !== mAta) begin
         nMismatched++;
         $display("[TB] FAIL %s ata: got %0b want %0b", tag, rpATA, mAta);
      end
      nCompared++;
      if ({rpDRY, rpPIP, rpSKDONE} !== 3'b100) begin
         nMismatched++;
         $display("[TB] FAIL %s dry/pip/skdone: got %b want 100", tag, {rpDRY, rpPIP, rpSKDONE});
      end
      nCompared++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      mCca = 0;
      mIvc = 1'b0;
      mAta = 1'b0;
      checkIdle("reset");
   endtask

   // Full seek or recal with per-cycle checking against the seek-time rule.
   // Optionally injects ignored strobes while busy (and a busy PRESET), and
   // optionally asserts ATACLR on the same edge that completes the seek.
   task automatic runSeek(input int tgtIn, input bit isRecal, input bit inject,
                          input bit injPreset, input bit clrAtDone);
      int tgt;
      int start;
      int d;
      int dir;
      int tDone;
      int injAt;
      int steps;
      int expCca;
      bit expDone;
      tgt   = isRecal ? 0 : tgtIn;
      start = mCca;
      d     = (tgt > start) ? (tgt - start) : (start - tgt);
      dir   = (tgt >= start) ? 1 : -1;
      tDone = d * S + ST + 2;
      injAt = $urandom_range(0, tDone - 1);
      rpDCA = isRecal ? 10'($urandom_range(0, 1023)) : 10'(tgt);
      if (isRecal) rpRECAL = 1'b1;
      else         rpSEEK  = 1'b1;
      tick();
      for (int k = 0; k <= tDone; k++) begin
         if (k > 0) tick();
         steps = (k == 0) ? 0 : (k - 1) / S;
         if (steps > d) steps = d;
         expCca  = start + dir * steps;
         expDone = (k == tDone);
         if (rpCCA !== 10'(expCca)) begin
            nMismatched++;
            $display("[TB] FAIL seek_cca k=%0d: got %0d want %0d", k, rpCCA, expCca);
         end
         nCompared++;
         if (rpDRY !== expDone) begin
            nMismatched++;
            $display("[TB] FAIL seek_dry k=%0d: got %0b want %0b", k, rpDRY, expDone);
         end
         nCompared++;
         if (rpPIP !== !expDone) begin
            nMismatched++;
            $display("[TB] FAIL seek_pip k=%0d: got %0b want %0b", k, rpPIP, !expDone);
         end
         nCompared++;
         if (rpSKDONE !== expDone) begin
            nMismatched++;
            $display("[TB] FAIL seek_skdone k=%0d: got %0b want %0b", k, rpSKDONE, expDone);
         end
         nCompared++;
         if (inject && k == injAt) begin
            rpSEEK   = 1'b1;
            rpDCA    = 10'd9;
            rpINCCYL = 1'b1;
            rpRECAL  = 1'($urandom_range(0, 1));
            if (injPreset) rpPRESET = 1'b1;
         end
         if (clrAtDone && k == tDone - 1) begin
            rpATACLR = 1'b1;
         end else if (!clrAtDone && k < tDone - 1 && $urandom_range(0, 7) == 0) begin
            rpATACLR = 1'b1;
         end
      end
      mCca = tgt;
      mAta = 1'b1;
      if (inject && injPreset) mIvc = 1'b0;
      if (rpATA !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL seek_ata_done: got %0b want 1", rpATA);
      end
      nCompared++;
      if (rpIVC !== mIvc) begin
         nMismatched++;
         $display("[TB] FAIL seek_ivc_done: got %0b want %0b", rpIVC, mIvc);
      end
      nCompared++;
      tick();
      checkIdle("after_seek");
   endtask

   task automatic test_ataclr();
      rpATACLR = 1'b1;
      tick();
      mAta = 1'b0;
      checkIdle("ataclr");
   endtask

   task automatic test_preset();
      rpPRESET = 1'b1;
      tick();
      mIvc = 1'b0;
      mAta = 1'b0;
      checkIdle("preset");
   endtask

   task automatic test_invalid(input int tgt);
      rpDCA  = 10'(tgt);
      rpSEEK = 1'b1;
      tick();
      mIvc = 1'b1;
      mAta = 1'b1;
      checkIdle("invalid_seek");
      tick();
      checkIdle("invalid_seek_hold");
   endtask

   task automatic test_inccyl(input int n);
      for (int i = 0; i < n; i++) begin
         rpINCCYL = 1'b1;
         tick();
         if (mCca == NC - 1) begin
            mIvc = 1'b1;
            mAta = 1'b1;
         end else begin
            mCca++;
         end
         checkIdle("inccyl");
      end
   endtask

   task automatic test_reset_mid();
      int tgt;
      tgt    = (mCca > 400) ? 0 : 800;
      rpDCA  = 10'(tgt);
      rpSEEK = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mCca = 0;
      mIvc = 1'b0;
      mAta = 1'b0;
      checkIdle("reset_mid");
      for (int i = 0; i < 40; i++) begin
         tick();
         if ({rpSKDONE, rpDRY, rpPIP} !== 3'b010) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_quiet: got %b want 010", {rpSKDONE, rpDRY, rpPIP});
         end
         nCompared++;
      end
      checkIdle("reset_mid_end");
   endtask

   task automatic test_random();
      int op;
      for (int i = 0; i < 12; i++) begin
         op = $urandom_range(0, 9);
         if (op <= 5)      runSeek($urandom_range(0, NC - 1), 1'b0, 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (op == 6) runSeek(0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         else if (op == 7) test_invalid($urandom_range(NC, 1023));
         else if (op == 8) test_inccyl($urandom_range(1, 3));
         else              test_ataclr();
      end
   endtask

   initial begin
      test_reset();
      // Basic seek 0 -> 5, then recal back and clear attention.
      runSeek(5, 1'b0, 1'b0, 1'b0, 1'b0);
      runSeek(0, 1'b1, 1'b0, 1'b0, 1'b0);
      test_ataclr();
      // Out-of-range cylinder, then preset clears the error.
      test_invalid(815);
      test_preset();
      // Zero-length seek still settles.
      runSeek(3, 1'b0, 1'b0, 1'b0, 1'b0);
      runSeek(3, 1'b0, 1'b0, 1'b0, 1'b0);
      // Strobes while busy are ignored; then increments in idle.
      runSeek(5, 1'b0, 1'b1, 1'b0, 1'b0);
      test_inccyl(3);
      // IVC survives a valid seek and is cleared by a busy PRESET.
      test_invalid(1000);
      runSeek(2, 1'b0, 1'b0, 1'b0, 1'b0);
      runSeek(6, 1'b0, 1'b1, 1'b1, 1'b0);
      // Completion and attention clear on the same edge.
      runSeek(1, 1'b0, 1'b0, 1'b0, 1'b1);
      // Increment saturation at the last cylinder.
      test_preset();
      runSeek(NC - 2, 1'b0, 1'b0, 1'b0, 1'b0);
      test_ataclr();
      test_inccyl(3);
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
